// File: rtl/bitty_pkg.sv
// Shared types and constants for the BittyPro control sequencer.
package bitty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD_S = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Instruction format codes carried in ir[1:0]
  localparam logic [1:0] FMT_REG = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;

  // Immediate-format operation codes carried in ir[4:2]
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_ADC = 3'd6,
    OP_CMP = 3'd7
  } op3_e;

  // Bus multiplexer sources beyond R0..R7
  localparam logic [3:0] MUX_IMM = 4'd8;
  localparam logic [3:0] MUX_C   = 4'd9;

  // ALU {mode, select} encodings
  localparam logic [4:0] ALU_ADD = 5'b0_1001;
  localparam logic [4:0] ALU_SUB = 5'b0_0110;
  localparam logic [4:0] ALU_AND = 5'b1_1110;
  localparam logic [4:0] ALU_OR  = 5'b1_1011;
  localparam logic [4:0] ALU_XOR = 5'b1_0110;
  localparam logic [4:0] ALU_MOV = 5'b1_1010;

  // Where the ALU carry_in comes from
  typedef enum logic [1:0] {
    CIN_ZERO = 2'd0,
    CIN_ONE  = 2'd1,
    CIN_FLAG = 2'd2
  } cin_e;

  typedef struct packed {
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        mode;
    logic [3:0]  select;
    cin_e        cin;
    logic [15:0] imm;
    logic        is_imm;
    logic        is_cmp;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/bitty_decode.sv
// Combinational instruction decoder: IR word -> operand/ALU control fields.
module bitty_decode
  import bitty_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  // Split the word by format; anything unrecognised is flagged illegal
  always_comb begin
    dec         = '0;
    dec.cin     = CIN_ZERO;
    dec.rx      = ir[15:13];
    dec.imm     = {8'h00, ir[12:5]};
    case (ir[1:0])
      FMT_REG: begin
        dec.ry      = ir[12:10];
        dec.select  = ir[9:6];
        dec.mode    = ir[5];
        dec.cin     = ir[4] ? CIN_FLAG : CIN_ZERO;
        dec.illegal = (ir[3:2] != 2'b00);
      end
      FMT_IMM: begin
        dec.is_imm = 1'b1;
        case (op3_e'(ir[4:2]))
          OP_ADD: {dec.mode, dec.select} = ALU_ADD;
          OP_SUB: begin
            {dec.mode, dec.select} = ALU_SUB;
            dec.cin                = CIN_ONE;
          end
          OP_AND: {dec.mode, dec.select} = ALU_AND;
          OP_OR:  {dec.mode, dec.select} = ALU_OR;
          OP_XOR: {dec.mode, dec.select} = ALU_XOR;
          OP_MOV: {dec.mode, dec.select} = ALU_MOV;
          OP_ADC: begin
            {dec.mode, dec.select} = ALU_ADD;
            dec.cin                = CIN_FLAG;
          end
          default: begin
            // cmp: a subtract whose result is never written back
            {dec.mode, dec.select} = ALU_SUB;
            dec.cin                = CIN_ONE;
            dec.is_cmp             = 1'b1;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bitty_control.sv
// Multi-cycle BittyPro control sequencer: FSM, instruction register and status flags.
module bitty_control
  import bitty_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        alu_carry_out,
  input  logic        alu_compare,
  output logic        en_i,
  output logic        en_s,
  output logic        en_c,
  output logic [7:0]  en_reg,
  output logic [3:0]  mux_sel,
  output logic [15:0] imm_out,
  output logic [3:0]  alu_select,
  output logic        alu_mode,
  output logic        alu_carry_in,
  output logic        carry_flag,
  output logic        eq_flag,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        carry_q, carry_d;
  logic        eq_q, eq_d;
  logic        illegal_q, illegal_d;
  logic [15:0] dec_src;
  dec_t        dec;

  // In FETCH the IR is not loaded yet, so the illegal check looks at the incoming word
  assign dec_src = (state_q == ST_FETCH) ? instruction : ir_q;

  bitty_decode u_decode (
    .ir  (dec_src),
    .dec (dec)
  );

  // State, IR and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      carry_q   <= 1'b0;
      eq_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      carry_q   <= carry_d;
      eq_q      <= eq_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = dec.illegal ? ST_DONE : ST_LOAD_S;
      ST_LOAD_S: state_d = ST_EXEC;
      ST_EXEC:   state_d = dec.is_cmp ? ST_DONE : ST_WB;
      ST_WB:     state_d = ST_DONE;
      ST_DONE:   state_d = run ? ST_FETCH : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // IR load, flag capture in EXEC, illegal sticky until the next FETCH
  always_comb begin
    ir_d      = ir_q;
    carry_d   = carry_q;
    eq_d      = eq_q;
    illegal_d = illegal_q;
    if (state_q == ST_FETCH) begin
      ir_d = instruction;
      if (dec.illegal) illegal_d = 1'b1;
    end
    if (state_d == ST_FETCH) illegal_d = 1'b0;
    if (state_q == ST_EXEC) begin
      eq_d = alu_compare;
      if (!dec.mode) carry_d = alu_carry_out;
    end
  end

  // Moore outputs decoded from state and IR
  always_comb begin
    en_i         = 1'b0;
    en_s         = 1'b0;
    en_c         = 1'b0;
    en_reg       = 8'h00;
    mux_sel      = 4'd0;
    alu_select   = 4'd0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_FETCH: en_i = 1'b1;
      ST_LOAD_S: begin
        mux_sel = {1'b0, dec.rx};
        en_s    = 1'b1;
      end
      ST_EXEC: begin
        mux_sel    = dec.is_imm ? MUX_IMM : {1'b0, dec.ry};
        alu_select = dec.select;
        alu_mode   = dec.mode;
        case (dec.cin)
          CIN_ONE:  alu_carry_in = 1'b1;
          CIN_FLAG: alu_carry_in = carry_q;
          default:  alu_carry_in = 1'b0;
        endcase
        en_c = 1'b1;
      end
      ST_WB: begin
        mux_sel = MUX_C;
        en_reg  = 8'b0000_0001 << dec.rx;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign imm_out    = dec.imm;
  assign carry_flag = carry_q;
  assign eq_flag    = eq_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_bitty_control.sv
// Directed testbench for bitty_control with a behavioural BittyPro datapath model.
module tb_bitty_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] instruction;
  logic        alu_carry_out, alu_compare;
  logic        en_i, en_s, en_c;
  logic [7:0]  en_reg;
  logic [3:0]  mux_sel;
  logic [15:0] imm_out;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in;
  logic        carry_flag, eq_flag, busy, done, illegal;

  bitty_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
    .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .en_i(en_i), .en_s(en_s), .en_c(en_c), .en_reg(en_reg),
    .mux_sel(mux_sel), .imm_out(imm_out), .alu_select(alu_select),
    .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .carry_flag(carry_flag), .eq_flag(eq_flag),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Datapath model: registers, S, C, bus and ALU
  logic [15:0] regs [8];
  logic [15:0] s_reg, c_reg, bus, alu_out;
  logic [16:0] sum;

  always_comb begin
    case (mux_sel)
      4'd8:    bus = imm_out;
      4'd9:    bus = c_reg;
      default: bus = (mux_sel < 4'd8) ? regs[mux_sel[2:0]] : 16'h0000;
    endcase
  end

  always_comb begin
    sum     = 17'h0;
    alu_out = 16'h0;
    case ({alu_mode, alu_select})
      5'b0_1001: begin sum = {1'b0, s_reg} + {1'b0, bus} + {16'h0, alu_carry_in}; alu_out = sum[15:0]; end
      5'b0_0110: begin sum = {1'b0, s_reg} + {1'b0, ~bus} + {16'h0, alu_carry_in}; alu_out = sum[15:0]; end
      5'b1_1110: alu_out = s_reg & bus;
      5'b1_1011: alu_out = s_reg | bus;
      5'b1_0110: alu_out = s_reg ^ bus;
      5'b1_1010: alu_out = bus;
      default:   alu_out = 16'h0;
    endcase
    alu_carry_out = sum[16];
    alu_compare   = (s_reg == bus);
  end

  always @(posedge clk) begin
    if (en_s) s_reg <= bus;
    if (en_c) c_reg <= alu_out;
    for (int i = 0; i < 8; i++)
      if (en_reg[i]) regs[i] <= bus;
  end

  // Checking
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_reg(input logic [2:0] rx, input logic [2:0] ry,
                                          input logic [3:0] sel, input logic mode, input logic uc);
    return {rx, ry, sel, mode, uc, 2'b00, 2'b00};
  endfunction

  function automatic logic [15:0] enc_imm(input logic [2:0] rx, input logic [7:0] imm,
                                          input logic [2:0] op);
    return {rx, imm, op, 2'b01};
  endfunction

  // Per-cycle trace of one instruction; index k = k-th cycle after run was sampled
  int         lat;
  logic [3:0] tr_mux [13];
  logic [7:0] tr_reg [13];
  logic [3:0] tr_sel [13];
  logic       tr_s [13], tr_c [13], tr_i [13], tr_cin [13];

  task automatic run_instr(input logic [15:0] ins);
    for (int k = 0; k < 13; k++) begin
      tr_mux[k] = 0; tr_reg[k] = 0; tr_sel[k] = 0;
      tr_s[k] = 0; tr_c[k] = 0; tr_i[k] = 0; tr_cin[k] = 0;
    end
    @(negedge clk);
    run = 1'b1;
    instruction = ins;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) run = 1'b0;
      tr_mux[k] = mux_sel; tr_reg[k] = en_reg; tr_sel[k] = alu_select;
      tr_s[k] = en_s; tr_c[k] = en_c; tr_i[k] = en_i; tr_cin[k] = alu_carry_in;
      if (done) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    $display("instr 0x%04h: done after %0d cycles, carry=%0b eq=%0b illegal=%0b",
             ins, lat, carry_flag, eq_flag, illegal);
  endtask

  logic bb_busy [12], bb_i [12], bb_done [12], bb_ill [12];
  logic [7:0] acc;

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    instruction = 16'h0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    s_reg = 16'h0;
    c_reg = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, illegal, carry_flag, eq_flag, en_i, en_s, en_c}, 0);
    chk("rst_en_reg", en_reg, 0);
    chk("rst_mux_alu", {mux_sel, alu_select, alu_mode, alu_carry_in}, 0);
    chk("rst_imm", imm_out, 0);

    // Register add R1 = R1 + R2
    regs[1] = 16'h0003;
    regs[2] = 16'h0004;
    run_instr(enc_reg(3'd1, 3'd2, 4'b1001, 1'b0, 1'b0));
    chk("add_lat", lat, 5);
    chk("add_en_i", tr_i[1], 1);
    chk("add_mux_ls", tr_mux[2], 1);
    chk("add_en_s", tr_s[2], 1);
    chk("add_mux_ex", tr_mux[3], 2);
    chk("add_sel_ex", tr_sel[3], 4'b1001);
    chk("add_en_c", tr_c[3], 1);
    chk("add_mux_wb", tr_mux[4], 9);
    chk("add_en_reg", tr_reg[4], 8'h02);
    chk("add_r1", regs[1], 16'h0007);
    chk("add_carry", carry_flag, 0);
    chk("add_idle", busy, 0);

    // Immediate sub R3 = 0x0010 - 0x11
    regs[3] = 16'h0010;
    run_instr(enc_imm(3'd3, 8'h11, 3'd1));
    chk("sub_lat", lat, 5);
    chk("sub_mux_ex", tr_mux[3], 8);
    chk("sub_cin", tr_cin[3], 1);
    chk("sub_r3", regs[3], 16'hFFFF);
    chk("sub_carry", carry_flag, 0);

    // adc R3 = 0xFFFF + 0x01 + carry(0)
    run_instr(enc_imm(3'd3, 8'h01, 3'd6));
    chk("adc_cin", tr_cin[3], 0);
    chk("adc_r3", regs[3], 16'h0000);
    chk("adc_carry", carry_flag, 1);

    // cmp R4 vs 0xAA
    regs[4] = 16'h00AA;
    run_instr(enc_imm(3'd4, 8'hAA, 3'd7));
    acc = 8'h0;
    for (int k = 1; k <= 12; k++) acc = acc | tr_reg[k];
    chk("cmp_lat", lat, 4);
    chk("cmp_eq", eq_flag, 1);
    chk("cmp_no_wb", acc, 0);
    chk("cmp_r4", regs[4], 16'h00AA);

    // Illegal format 11, then register format with nonzero reserved bits
    for (int t = 0; t < 2; t++) begin
      run_instr((t == 0) ? 16'hFFFF : 16'h2A44);
      acc = 8'h0;
      for (int k = 1; k <= 12; k++) acc = acc | tr_reg[k] | {6'h0, tr_s[k], tr_c[k]};
      chk("ill_lat", lat, 2);
      chk("ill_flag", illegal, 1);
      chk("ill_no_dp", acc, 0);
      chk("ill_flags_kept", {carry_flag, eq_flag}, 2'b11);
    end

    // Back-to-back: mov R5,0x5A then or R5,0x0F with run held high
    @(negedge clk);
    run = 1'b1;
    instruction = enc_imm(3'd5, 8'h5A, 3'd5);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bb_busy[k] = busy; bb_i[k] = en_i; bb_done[k] = done; bb_ill[k] = illegal;
      if (k == 2) instruction = enc_imm(3'd5, 8'h0F, 3'd3);
      if (k == 6) run = 1'b0;
    end
    acc = 8'h1;
    for (int k = 1; k <= 10; k++) acc[0] = acc[0] & bb_busy[k];
    $display("back-to-back mov/or: R5=0x%04h", regs[5]);
    chk("b2b_ill_clr", bb_ill[1], 0);
    chk("b2b_done1", bb_done[5], 1);
    chk("b2b_fetch2", bb_i[6], 1);
    chk("b2b_done2", bb_done[10], 1);
    chk("b2b_busy", acc[0], 1);
    chk("b2b_idle", bb_busy[11], 0);
    chk("b2b_r5", regs[5], 16'h005F);

    // Reset pulsed during EXEC of add R1 = R1 + R2
    @(negedge clk);
    run = 1'b1;
    instruction = enc_reg(3'd1, 3'd2, 4'b1001, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) run = 1'b0;
    end
    chk("abort_in_exec", en_c, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {en_c, en_s, en_reg, mux_sel, alu_select, alu_mode, alu_carry_in}, 0);
    chk("abort_flags", {carry_flag, eq_flag, illegal, done}, 0);
    chk("abort_imm", imm_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset abort: R1=0x%04h busy=%0b", regs[1], busy);
    chk("abort_no_wb", regs[1], 16'h0007);
    chk("abort_still_idle", busy, 0);
    run_instr(enc_reg(3'd1, 3'd2, 4'b1001, 1'b0, 1'b0));
    chk("post_lat", lat, 5);
    chk("post_r1", regs[1], 16'h000B);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bitty_control.md
# bitty_control

Multi-cycle control sequencer for the BittyPro datapath, acting as the initiator that drives the 16-bit ALU. It latches one instruction per `run` request, then steps the shared bus multiplexer, the S/C staging registers, the eight general registers and the ALU `select`/`mode`/`carry_in` inputs. It also captures the ALU's `carry_out` and `compare` results into status flags. It sits between instruction memory and the datapath.

## Interface
Parameters
- none; widths are fixed by the BittyPro datapath (16-bit data, 8 registers).

Ports
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: request to execute `instruction`; sampled in IDLE and DONE.
- `instruction` in 16: instruction word, valid while `run`=1.
- `alu_carry_out` in 1: ALU `carry_out`.
- `alu_compare` in 1: ALU `compare` (in_a == in_b).
- `en_i` out 1: load the instruction register.
- `en_s` out 1: load S (ALU in_a) from the bus.
- `en_c` out 1: load C from the ALU output.
- `en_reg` out 8: one-hot write enable for R0..R7, loaded from the bus.
- `mux_sel` out 4: bus source. 0-7 selects R0-R7, 8 selects `imm_out`, 9 selects C.
- `imm_out` out 16: zero-extended imm8.
- `alu_select` out 4, `alu_mode` out 1, `alu_carry_in` out 1: ALU controls.
- `carry_flag` out 1, `eq_flag` out 1: status flags.
- `busy` out 1, `done` out 1, `illegal` out 1: status outputs.

## Operation
Instruction format is set by bits [1:0].
- **00, register:** [15:13] rx, [12:10] ry, [9:6] select, [5] mode, [4] use_carry, [3:2] must be 0.
  - `alu_carry_in` = use_carry & carry_flag.
- **01, immediate:** [15:13] rx, [12:5] imm8, [4:2] op3. op3 maps to {mode, select, carry_in}:
  - 000 add {0,1001,0}; 001 sub {0,0110,1}; 010 and {1,1110,x=0}; 011 or {1,1011,0}
  - 100 xor {1,0110,0}; 101 mov {1,1010,0}; 110 adc {0,1001,carry_flag}; 111 cmp {0,0110,1}, with no writeback.
- **10, 11, or nonzero reserved bits:** illegal.

States: IDLE, FETCH, LOAD_S, EXEC, WB, DONE.
- IDLE: when `run`=1, go to FETCH.
- FETCH: `en_i`=1. Decode is taken from the latched IR in the next cycle.
- LOAD_S: `mux_sel`=rx, `en_s`=1. An illegal IR skips LOAD_S/EXEC/WB, goes straight to DONE and sets `illegal`.
- EXEC: `mux_sel`=ry or 8, ALU controls driven, `en_c`=1.
  - `eq_flag` <= `alu_compare` always.
  - `carry_flag` <= `alu_carry_out` only when mode=0.
  - cmp goes next to DONE; all other instructions go to WB.
- WB: `mux_sel`=9, `en_reg`[rx]=1.
- DONE: `done`=1 for one cycle. If `run`=1 go to FETCH (back-to-back), else IDLE.

Output rules:
- `busy`=1 in every state except IDLE.
- `illegal` holds until the next FETCH.
- Outside their states, all enables are 0, `mux_sel`=0 and ALU controls are 0.
- rx = ry is legal; rx = R0 is writable (no hardwired zero).

## Timing
- Reset: state IDLE. All outputs are 0, including flags, `imm_out` and IR.
- Enables are Moore outputs decoded from state and IR. ALU controls are stable for all of EXEC.
- Latency from `run` sampled to `done`:
  - register / immediate non-cmp: 5 cycles (FETCH, LOAD_S, EXEC, WB, DONE).
  - cmp: 4 cycles.
  - illegal: 2 cycles.
- `run` asserted in any state other than IDLE/DONE is ignored. No queueing.
- `rst_n` low mid-instruction aborts immediately. No register write occurs after the reset edge. Flags clear.
- adc uses the `carry_flag` value from before the current EXEC.

## Structure
- Shared package `bitty_pkg`:
  - state enum
  - format codes
  - op3 codes
  - `mux_sel` constants (MUX_IMM=8, MUX_C=9)
  - ALU {mode,select} constants for add/sub/and/or/xor/mov
- One sub-module, `bitty_decode`: combinational IR -> {rx, ry, mode, select, carry source, imm, is_cmp, illegal}. The FSM and flags stay in `bitty_control`.

## Test plan
- Register add, R1=0x0003, R2=0x0004, mode=0 select=1001 → `mux_sel` 1, 2, 9 in successive cycles. `en_reg`=0x02 in WB. `done` on cycle 5. With a model ALU, R1=0x0007, carry_flag=0.
- Immediate sub, R3=0x0010, imm8=0x11 → result 0xFFFF and carry_flag=0. Then adc imm 0x01 to R3 → 0x0000, carry_flag=1.
- cmp: R4=0x00AA vs imm 0xAA → eq_flag=1. No `en_reg` pulse. `done` 4 cycles after `run`.
- Illegal format 11 → `illegal`=1, `done` 2 cycles after `run`, no `en_s`/`en_c`/`en_reg` activity, flags unchanged.
- Back-to-back: `run` held high across two instructions → second FETCH directly follows DONE. `busy` stays high throughout.
- `rst_n` pulsed low during EXEC → next edge shows IDLE, all outputs 0, no WB pulse. A subsequent `run` executes normally.
